// File: rtl/ce_gen_pkg.sv
// Shared types for the multi-channel clock-enable generator.
// The packed config struct here is sized for the default accumulator width.
package ce_gen_pkg;

  localparam int ACC_W_DEFAULT = 16;

  typedef enum logic {CE_MODE_INT, CE_MODE_FRAC} ce_mode_t;

  typedef struct packed {
    ce_mode_t                 mode;
    logic                     en;
    logic [ACC_W_DEFAULT-1:0] val;
  } ce_cfg_t;

endpackage

// File: rtl/ce_gen_chan.sv
// One enable channel: active and shadow configuration, divide counter or phase
// accumulator, registered ce pulse and clk_out toggle.
module ce_gen_chan
  import ce_gen_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEFAULT,
  parameter int RESET_DIV = 5
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             pause,
  input  logic             resync,
  input  logic             wr,
  input  ce_mode_t         wr_mode,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_val,
  output logic             ce,
  output logic             clk_out,
  output logic             cfg_pending
);

  typedef struct packed {
    ce_mode_t         mode;
    logic             en;
    logic [ACC_W-1:0] val;
  } chan_cfg_t;

  localparam chan_cfg_t RESET_CFG = '{mode: CE_MODE_INT, en: 1'b1, val: ACC_W'(RESET_DIV)};

  chan_cfg_t        act_p1, shd_p1, act_p0, shd_p0, wr_cfg;
  logic [ACC_W-1:0] cnt_p1, cnt_p0, last_cnt;
  logic [ACC_W:0]   sum;
  logic             pend_p1, pend_p0, tog_p1, tog_p0, ce_p1, ce_p0;
  logic             fire, stalled;

  always_comb begin
    wr_cfg   = '{mode: wr_mode, en: wr_en, val: wr_val};
    // Divisors 0 and 1 both mean "every cycle".
    last_cnt = (act_p1.val <= ACC_W'(1)) ? '0 : act_p1.val - ACC_W'(1);
    sum      = {1'b0, cnt_p1} + {1'b0, act_p1.val};
    stalled  = !act_p1.en || (act_p1.mode == CE_MODE_FRAC && act_p1.val == '0);

    fire = 1'b0;
    if (act_p1.en && !pause && !resync) begin
      if (act_p1.mode == CE_MODE_INT) fire = (cnt_p1 == last_cnt);
      else                            fire = sum[ACC_W];
    end

    act_p0  = act_p1;
    shd_p0  = shd_p1;
    pend_p0 = pend_p1;
    cnt_p0  = cnt_p1;
    tog_p0  = tog_p1;
    ce_p0   = fire;

    if (resync) begin
      cnt_p0 = '0;
      tog_p0 = 1'b0;
      // A write arriving with resync bypasses the shadow entirely.
      if (wr) begin
        act_p0  = wr_cfg;
        pend_p0 = 1'b0;
      end else if (pend_p1) begin
        act_p0  = shd_p1;
        pend_p0 = 1'b0;
      end
    end else begin
      if (!act_p1.en) begin
        cnt_p0 = '0;
      end else if (!pause) begin
        if (act_p1.mode == CE_MODE_INT) cnt_p0 = fire ? '0 : cnt_p1 + ACC_W'(1);
        else                            cnt_p0 = sum[ACC_W-1:0];
      end

      if (fire) tog_p0 = ~tog_p1;

      // Pending shadow lands on the ce edge, or immediately if the channel can never fire.
      if (pend_p1 && (fire || stalled)) begin
        act_p0  = shd_p1;
        cnt_p0  = '0;
        pend_p0 = 1'b0;
      end

      if (wr) begin
        if (stalled) begin
          act_p0  = wr_cfg;
          cnt_p0  = '0;
          pend_p0 = 1'b0;
        end else begin
          shd_p0  = wr_cfg;
          pend_p0 = 1'b1;
        end
      end
    end
  end

  // Stage p1: channel state and registered outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      act_p1  <= RESET_CFG;
      shd_p1  <= RESET_CFG;
      pend_p1 <= 1'b0;
      cnt_p1  <= '0;
      tog_p1  <= 1'b0;
      ce_p1   <= 1'b0;
    end else begin
      act_p1  <= act_p0;
      shd_p1  <= shd_p0;
      pend_p1 <= pend_p0;
      cnt_p1  <= cnt_p0;
      tog_p1  <= tog_p0;
      ce_p1   <= ce_p0;
    end
  end

  assign ce          = ce_p1;
  assign clk_out     = tog_p1;
  assign cfg_pending = pend_p1;

endmodule

// File: rtl/ce_gen_multi.sv
// NUM_CH independent clock-enable channels with shared pause/resync and a
// single addressed configuration port.
module ce_gen_multi
  import ce_gen_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  ACC_W     = ACC_W_DEFAULT,
  parameter int  RESET_DIV = 5,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pause,
  input  logic              resync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_mode,
  input  logic              cfg_en,
  input  logic [ACC_W-1:0]  cfg_val,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] cfg_pending
);

  ce_mode_t cfg_mode_e;

  assign cfg_mode_e = ce_mode_t'(cfg_mode);

  // Channel numbers at or above NUM_CH match no instance and are dropped.
  for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
    logic ch_wr;

    assign ch_wr = cfg_we && (cfg_ch == CH_W'(n));

    ce_gen_chan #(
      .ACC_W     (ACC_W),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .pause       (pause),
      .resync      (resync),
      .wr          (ch_wr),
      .wr_mode     (cfg_mode_e),
      .wr_en       (cfg_en),
      .wr_val      (cfg_val),
      .ce          (ce[n]),
      .clk_out     (clk_out[n]),
      .cfg_pending (cfg_pending[n])
    );
  end

endmodule

// File: tb/tb_ce_gen_multi.sv
// Scoreboard bench: stimulus queues hand-computed ce pulse cycles per channel,
// a negedge monitor pops one entry for every ce pulse it sees.
module tb_ce_gen_multi;

  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int CW  = 2;

  logic           clk_sys = 1'b0;
  logic           reset = 1'b1, pause = 1'b0, resync = 1'b0;
  logic           cfg_we = 1'b0, cfg_mode = 1'b0, cfg_en = 1'b0;
  logic [CW-1:0]  cfg_ch = '0;
  logic [AW-1:0]  cfg_val = '0;
  logic [NCH-1:0] ce, clk_out, cfg_pending;

  int cyc = 0;
  int checks = 0, errors = 0;
  int q0[$], q1[$], q2[$];
  logic [NCH-1:0] chk_en = '1;
  int win_lo = 0, win_hi = -1;
  int free_cnt [NCH] = '{default: 0};

  ce_gen_multi #(.NUM_CH(NCH), .ACC_W(AW), .RESET_DIV(5)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .pause       (pause),
    .resync      (resync),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_mode    (cfg_mode),
    .cfg_en      (cfg_en),
    .cfg_val     (cfg_val),
    .ce          (ce),
    .clk_out     (clk_out),
    .cfg_pending (cfg_pending)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  always @(negedge clk_sys) begin : mon
    int  exp_t;
    bit  have;
    for (int ch = 0; ch < NCH; ch++) begin
      if (ce[ch] && chk_en[ch]) begin
        have  = 1'b0;
        exp_t = 0;
        case (ch)
          0: if (q0.size() > 0) begin exp_t = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin exp_t = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin exp_t = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL ce%0d unexpected pulse at cycle %0d (no pulse required)", ch, cyc);
        end else if (exp_t != cyc) begin
          errors++;
          $display("FAIL ce%0d pulse at cycle %0d, required at cycle %0d", ch, cyc, exp_t);
        end
      end else if (ce[ch] && cyc >= win_lo && cyc <= win_hi) begin
        free_cnt[ch]++;
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_exp(input int ch, input int t);
    case (ch)
      0: q0.push_back(t);
      1: q1.push_back(t);
      default: q2.push_back(t);
    endcase
  endtask

  task automatic push_periodic(input int ch, input int first, input int period, input int n);
    for (int i = 0; i < n; i++) push_exp(ch, first + i * period);
  endtask

  task automatic chk(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b required %b", name, cyc, got, req);
    end
  endtask

  task automatic chk_drained(input string name);
    int left;
    left = q0.size() + q1.size() + q2.size();
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL %s: %0d required ce pulses never seen (q0=%0d q1=%0d q2=%0d)",
               name, left, q0.size(), q1.size(), q2.size());
      q0.delete(); q1.delete(); q2.delete();
    end
  endtask

  task automatic cfg_write(input int ch, input logic mode, input logic en, input logic [AW-1:0] val);
    cfg_ch = CW'(ch); cfg_mode = mode; cfg_en = en; cfg_val = val; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_resync(input bit wr, input int ch, input logic mode, input logic en,
                           input logic [AW-1:0] val, input bit with_pause, output int r);
    resync = 1'b1;
    pause  = with_pause;
    if (wr) begin
      cfg_ch = CW'(ch); cfg_mode = mode; cfg_en = en; cfg_val = val; cfg_we = 1'b1;
    end
    tick();
    resync = 1'b0; pause = 1'b0; cfg_we = 1'b0;
    r = cyc;
  endtask

  initial begin
    int e0, r, r3, r4, r5, r6;

    // Reset state
    tick(); tick();
    chk("reset_ce", ce, 3'b000);
    chk("reset_clk_out", clk_out, 3'b000);
    chk("reset_pending", cfg_pending, 3'b000);
    reset = 1'b0;
    e0 = cyc;

    // 1: default divide-by-5 on every channel
    for (int ch = 0; ch < NCH; ch++) push_periodic(ch, e0 + 5, 5, 4);
    wait_until(e0 + 7);  chk("t1_clk_out_a", clk_out, 3'b111);
    wait_until(e0 + 12); chk("t1_clk_out_b", clk_out, 3'b000);
    wait_until(e0 + 17); chk("t1_clk_out_c", clk_out, 3'b111);
    wait_until(e0 + 22); chk("t1_clk_out_d", clk_out, 3'b000);
    chk_drained("t1_drained");

    // 2: ch1 fractional 0x4000, then 0x6666 through the shadow
    do_resync(1'b1, 1, 1'b1, 1'b1, 16'h4000, 1'b0, r);
    chk("t2_resync_clk_out", clk_out, 3'b000);
    chk("t2_resync_pending", cfg_pending, 3'b000);
    push_periodic(1, r + 4, 4, 5);
    push_periodic(0, r + 5, 5, 204);
    push_periodic(2, r + 5, 5, 204);
    wait_until(r + 5);  chk("t2_clk_out_a", clk_out, 3'b111);
    wait_until(r + 9);  chk("t2_clk_out_b", clk_out, 3'b101);
    wait_until(r + 13); chk("t2_clk_out_c", clk_out, 3'b010);
    wait_until(r + 17);
    cfg_write(1, 1'b1, 1'b1, 16'h6666);
    chk("t2_pending_set", cfg_pending, 3'b010);
    wait_until(r + 20); chk("t2_pending_clr", cfg_pending, 3'b000);
    wait_until(r + 21);
    free_cnt[1] = 0; win_lo = r + 21; win_hi = r + 1020; chk_en[1] = 1'b0;
    wait_until(r + 1022);
    checks++;
    if (free_cnt[1] < 399 || free_cnt[1] > 400) begin
      errors++;
      $display("FAIL t2_frac_rate: %0d pulses in 1000 cycles, required 399..400", free_cnt[1]);
    end
    chk_drained("t2_drained");

    // 3: ch0 div 5 -> 3 written at cnt=1, then div 4 written on a ce edge
    do_resync(1'b1, 1, 1'b0, 1'b1, 16'd5, 1'b0, r3);
    chk_en[1] = 1'b1;
    chk("t3_resync_pending", cfg_pending, 3'b000);
    push_periodic(1, r3 + 5, 5, 4);
    push_periodic(2, r3 + 5, 5, 4);
    push_exp(0, r3 + 5);  push_exp(0, r3 + 8);  push_exp(0, r3 + 11);
    push_exp(0, r3 + 14); push_exp(0, r3 + 18); push_exp(0, r3 + 22);
    wait_until(r3 + 1);
    cfg_write(0, 1'b0, 1'b1, 16'd3);
    chk("t3_pending_a", cfg_pending, 3'b001);
    wait_until(r3 + 4);  chk("t3_pending_b", cfg_pending, 3'b001);
    wait_until(r3 + 5);  chk("t3_pending_c", cfg_pending, 3'b000);
    wait_until(r3 + 10);
    cfg_write(0, 1'b0, 1'b1, 16'd4);
    chk("t3_pending_ce_edge", cfg_pending, 3'b001);
    wait_until(r3 + 13); chk("t3_pending_d", cfg_pending, 3'b001);
    wait_until(r3 + 14); chk("t3_pending_e", cfg_pending, 3'b000);
    wait_until(r3 + 23);
    chk_drained("t3_drained");

    // 4: pause for 7 edges mid-period (ch0 div 4, ch1/ch2 div 5)
    do_resync(1'b0, 0, 1'b0, 1'b0, 16'd0, 1'b0, r4);
    push_exp(0, r4 + 11); push_exp(0, r4 + 15); push_exp(0, r4 + 19);
    push_exp(1, r4 + 12); push_exp(1, r4 + 17);
    push_exp(2, r4 + 12); push_exp(2, r4 + 17);
    wait_until(r4 + 1);
    pause = 1'b1;
    wait_until(r4 + 5); chk("t4_paused_ce", ce, 3'b000);
    wait_until(r4 + 8);
    pause = 1'b0;
    wait_until(r4 + 13); chk("t4_clk_out", clk_out, 3'b111);
    wait_until(r4 + 20);
    cfg_write(1, 1'b0, 1'b1, 16'd7);
    chk("t4_pending", cfg_pending, 3'b010);
    chk("t4_clk_out_end", clk_out, 3'b001);
    chk_drained("t4_drained");

    // 5: resync + pause + direct write of ch2 div 2; pending ch1 div 7 applies
    do_resync(1'b1, 2, 1'b0, 1'b1, 16'd2, 1'b1, r5);
    chk("t5_clk_out", clk_out, 3'b000);
    chk("t5_pending", cfg_pending, 3'b000);
    push_periodic(2, r5 + 2, 2, 5);
    push_exp(0, r5 + 4); push_exp(0, r5 + 8);
    push_exp(1, r5 + 7);

    // 6: out-of-range write, stalled-channel write, disabling ch2
    wait_until(r5 + 9);
    cfg_write(3, 1'b1, 1'b0, 16'd0);
    chk("t6_out_of_range", cfg_pending, 3'b000);
    do_resync(1'b1, 1, 1'b1, 1'b1, 16'd0, 1'b0, r6);
    chk_drained("t5_drained");
    push_periodic(0, r6 + 4, 4, 7);
    push_periodic(1, r6 + 4, 3, 9);
    push_exp(2, r6 + 2); push_exp(2, r6 + 4);
    cfg_write(1, 1'b0, 1'b1, 16'd3);
    chk("t6_stalled_immediate", cfg_pending, 3'b000);
    cfg_write(2, 1'b0, 1'b0, 16'd2);
    chk("t6_disable_pending_a", cfg_pending, 3'b100);
    wait_until(r6 + 3); chk("t6_disable_pending_b", cfg_pending, 3'b100);
    wait_until(r6 + 4); chk("t6_disable_pending_c", cfg_pending, 3'b000);
    wait_until(r6 + 10); chk("t6_clk_out", clk_out, 3'b010);
    wait_until(r6 + 30);
    chk("t6_clk_out_hold", clk_out[2:2], 1'b0);
    chk_drained("t6_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
